// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-scan sequencer and its box checker.
package edge_pkg;
  localparam int EDGE_X_W = 11;
  localparam int EDGE_Y_W = 10;
  localparam int CMP_W    = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_SCAN,
    ST_CHECK
  } state_e;

  typedef struct packed {
    logic [EDGE_X_W-1:0] right;
    logic [EDGE_X_W-1:0] left;
    logic [EDGE_Y_W-1:0] top;
    logic [EDGE_Y_W-1:0] bot;
  } box_t;

  // Round-half-up mean; 12 bits hold the sum of two 11-bit edges plus one.
  function automatic logic [CMP_W-1:0] avg_up(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b);
    return (a + b + CMP_W'(1)) >> 1;
  endfunction
endpackage

// File: rtl/edge_scan_ctrl_if.sv
// Finder/display/framebuffer-port bundle; master is the sequencer's view, slave the environment's.
interface edge_scan_if #(
  parameter int ADDR_W = 17
);
  import edge_pkg::*;

  logic                ef_start_out;
  logic [EDGE_X_W-1:0] ef_x_center_out;
  logic [EDGE_Y_W-1:0] ef_y_center_out;
  logic [ADDR_W-1:0]   ef_addr_in;
  logic                ef_valid_in;
  logic [EDGE_X_W-1:0] ef_right_in;
  logic [EDGE_X_W-1:0] ef_left_in;
  logic [EDGE_Y_W-1:0] ef_top_in;
  logic [EDGE_Y_W-1:0] ef_bot_in;
  logic                disp_req_in;
  logic [ADDR_W-1:0]   disp_addr_in;
  logic                disp_gnt_out;
  logic [ADDR_W-1:0]   mem_addr_out;

  modport master (
    output ef_start_out, ef_x_center_out, ef_y_center_out, disp_gnt_out, mem_addr_out,
    input  ef_addr_in, ef_valid_in, ef_right_in, ef_left_in, ef_top_in, ef_bot_in,
           disp_req_in, disp_addr_in
  );

  modport slave (
    input  ef_start_out, ef_x_center_out, ef_y_center_out, disp_gnt_out, mem_addr_out,
    output ef_addr_in, ef_valid_in, ef_right_in, ef_left_in, ef_top_in, ef_bot_in,
           disp_req_in, disp_addr_in
  );
endinterface

// File: rtl/edge_box_check.sv
// Combinational sanity check of a finder bounding box against frame bounds and minimum size.
module edge_box_check
  import edge_pkg::*;
#(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int MIN_BOX = 16
) (
  input  box_t box_in,
  output logic accept_out
);
  logic [CMP_W-1:0] r, l, t, b, w, h;

  always_comb begin
    r = CMP_W'(box_in.right);
    l = CMP_W'(box_in.left);
    t = CMP_W'(box_in.top);
    b = CMP_W'(box_in.bot);
    // Extents only matter once ordering holds, so the subtraction never wraps where it counts.
    w = r - l + CMP_W'(1);
    h = b - t + CMP_W'(1);
    accept_out = (l < r) && (t < b) &&
                 (r < CMP_W'(WIDTH)) && (b < CMP_W'(HEIGHT)) &&
                 (w >= CMP_W'(MIN_BOX)) && (h >= CMP_W'(MIN_BOX));
  end
endmodule

// File: rtl/edge_scan_ctrl.sv
// Per-frame edge-scan sequencer and framebuffer read-port arbiter with box validation and lock status.
// Define EDGE_BOX_SMOOTH_EN to blend accepted boxes with the previous one while locked.
module edge_scan_ctrl
  import edge_pkg::*;
#(
  parameter int WIDTH          = 240,
  parameter int HEIGHT         = 320,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MIN_BOX        = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic                frame_done_in,
  input  logic [EDGE_X_W-1:0] x_center_in,
  input  logic [EDGE_Y_W-1:0] y_center_in,
  edge_scan_if.master         bus,
  output logic [EDGE_X_W-1:0] box_right_out,
  output logic [EDGE_X_W-1:0] box_left_out,
  output logic [EDGE_Y_W-1:0] box_top_out,
  output logic [EDGE_Y_W-1:0] box_bot_out,
  output logic                box_valid_out,
  output logic                locked_out,
  output logic                err_timeout_out,
  output logic                busy_out
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]          rst_sync_q;
  logic                rst_n;
  state_e              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                en_q;
  logic [EDGE_X_W-1:0] xc_q, xc_d;
  logic [EDGE_Y_W-1:0] yc_q, yc_d;
  box_t                cap_q, cap_d, box_q, box_d;
  logic                box_vld_q, box_vld_d, locked_q, locked_d, err_q, err_d;
  logic [1:0]          fail_q, fail_d;
  logic                timeout, accept, fail_event, scan_own;

  // Reset asserts asynchronously everywhere but releases on a clock edge.
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];

  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;

  assign timeout = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable_in) state_d = ST_ARM;
      ST_ARM:   if (!enable_in) state_d = ST_IDLE;
                else if (frame_done_in) state_d = ST_START;
      ST_START: state_d = ST_SCAN;
      // Enable is only re-examined when the scan finishes.
      ST_SCAN:  if (bus.ef_valid_in) state_d = ST_CHECK;
                else if (timeout) state_d = enable_in ? ST_ARM : ST_IDLE;
      ST_CHECK: state_d = enable_in ? ST_ARM : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    scan_own         = (state_q == ST_START) || (state_q == ST_SCAN);
    busy_out         = scan_own;
    bus.ef_start_out = (state_q == ST_START);
    bus.mem_addr_out = scan_own ? bus.ef_addr_in : bus.disp_addr_in;
    bus.disp_gnt_out = scan_own ? 1'b0 : bus.disp_req_in;
  end

  edge_box_check #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .MIN_BOX(MIN_BOX)) u_chk (
    .box_in    (cap_q),
    .accept_out(accept)
  );

  always_comb begin
    cnt_d      = cnt_q;
    xc_d       = xc_q;
    yc_d       = yc_q;
    cap_d      = cap_q;
    box_d      = box_q;
    box_vld_d  = 1'b0;
    locked_d   = locked_q;
    fail_d     = fail_q;
    err_d      = err_q;
    fail_event = 1'b0;
    if (enable_in && !en_q) err_d = 1'b0;
    case (state_q)
      ST_START: begin
        cnt_d = '0;
        xc_d  = x_center_in;
        yc_d  = y_center_in;
      end
      ST_SCAN: begin
        cnt_d = cnt_q + TW'(1);
        if (bus.ef_valid_in) begin
          cap_d.right = bus.ef_right_in;
          cap_d.left  = bus.ef_left_in;
          cap_d.top   = bus.ef_top_in;
          cap_d.bot   = bus.ef_bot_in;
        end else if (timeout) begin
          err_d      = 1'b1;
          fail_event = 1'b1;
        end
      end
      ST_CHECK: begin
        if (accept) begin
`ifdef EDGE_BOX_SMOOTH_EN
          if (locked_q) begin
            box_d.right = EDGE_X_W'(avg_up(CMP_W'(box_q.right), CMP_W'(cap_q.right)));
            box_d.left  = EDGE_X_W'(avg_up(CMP_W'(box_q.left),  CMP_W'(cap_q.left)));
            box_d.top   = EDGE_Y_W'(avg_up(CMP_W'(box_q.top),   CMP_W'(cap_q.top)));
            box_d.bot   = EDGE_Y_W'(avg_up(CMP_W'(box_q.bot),   CMP_W'(cap_q.bot)));
          end else begin
            box_d = cap_q;
          end
`else
          box_d = cap_q;
`endif
          box_vld_d = 1'b1;
          locked_d  = 1'b1;
          fail_d    = '0;
        end else begin
          fail_event = 1'b1;
        end
      end
      default: ;
    endcase
    if (fail_event) begin
      fail_d = (fail_q == 2'd3) ? fail_q : fail_q + 2'd1;
      if (int'(fail_d) >= MAX_RETRY) locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      cnt_q     <= '0;
      en_q      <= 1'b0;
      xc_q      <= '0;
      yc_q      <= '0;
      cap_q     <= '0;
      box_q     <= '0;
      box_vld_q <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      en_q      <= enable_in;
      xc_q      <= xc_d;
      yc_q      <= yc_d;
      cap_q     <= cap_d;
      box_q     <= box_d;
      box_vld_q <= box_vld_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
    end

  assign bus.ef_x_center_out = xc_q;
  assign bus.ef_y_center_out = yc_q;
  assign box_right_out       = box_q.right;
  assign box_left_out        = box_q.left;
  assign box_top_out         = box_q.top;
  assign box_bot_out         = box_q.bot;
  assign box_valid_out       = box_vld_q;
  assign locked_out          = locked_q;
  assign err_timeout_out     = err_q;
endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Randomized scan-level bench for edge_scan_ctrl against a box/lock/error reference model.
module tb_edge_scan_ctrl;
  import edge_pkg::*;

  localparam int W = 240, H = 320, T = 64, MINB = 16, MAXR = 3;
  localparam int AW = $clog2(W * H);

  logic                clk = 1'b0, rst_n = 1'b0, enable = 1'b0, frame_done = 1'b0;
  logic [EDGE_X_W-1:0] xc = '0, br, bl;
  logic [EDGE_Y_W-1:0] yc = '0, bt, bb;
  logic                bvld, locked, err, busy;
  int                  n_tests = 0, n_fail = 0;

  // Reference model state, kept as plain integers.
  int m_l = 0, m_r = 0, m_t = 0, m_b = 0, m_fails = 0;
  bit m_have = 0, m_err = 0, m_en = 0;

  edge_scan_if #(.ADDR_W(AW)) bus ();

  edge_scan_ctrl #(
    .WIDTH(W), .HEIGHT(H), .TIMEOUT_CYCLES(T), .MIN_BOX(MINB), .MAX_RETRY(MAXR)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .enable_in(enable), .frame_done_in(frame_done),
    .x_center_in(xc), .y_center_in(yc), .bus(bus),
    .box_right_out(br), .box_left_out(bl), .box_top_out(bt), .box_bot_out(bb),
    .box_valid_out(bvld), .locked_out(locked), .err_timeout_out(err), .busy_out(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit ref_accept(input int l, r, t, b);
    return (l < r) && (t < b) && (r < W) && (b < H) && (r - l + 1 >= MINB) && (b - t + 1 >= MINB);
  endfunction

  function automatic bit m_locked();
    return m_have && (m_fails < MAXR);
  endfunction

  task automatic model_reset();
    m_l = 0; m_r = 0; m_t = 0; m_b = 0; m_fails = 0; m_have = 0; m_err = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_right"}, br, m_r);
    chk({tag, "_left"}, bl, m_l);
    chk({tag, "_top"}, bt, m_t);
    chk({tag, "_bot"}, bb, m_b);
    chk({tag, "_locked"}, locked, m_locked());
    chk({tag, "_err"}, err, m_err);
  endtask

  // Randomize both requesters and check who owns the framebuffer port.
  task automatic arb_step(input bit own);
    bus.ef_addr_in   = AW'($urandom);
    bus.disp_addr_in = AW'($urandom);
    bus.disp_req_in  = 1'($urandom_range(0, 1));
    #1;
    chk("busy", busy, own);
    chk("mem_addr", bus.mem_addr_out, own ? bus.ef_addr_in : bus.disp_addr_in);
    chk("disp_gnt", bus.disp_gnt_out, own ? 1'b0 : bus.disp_req_in);
  endtask

  task automatic set_enable(input bit v);
    enable = v;
    if (v && !m_en) m_err = 0;
    m_en = v;
    @(negedge clk);
  endtask

  // One scan from ARM. dly in [0,T-1]: finder answers on that SCAN cycle; otherwise it never does.
  // rst_at >= 0: reset is asserted on that SCAN cycle and the task returns.
  task automatic do_scan(input int dly, input int l, r, t, b, input int rst_at);
    int k;
    bit acc, give;
    give = (dly >= 0) && (dly < T);
    xc = EDGE_X_W'($urandom);
    yc = EDGE_Y_W'($urandom);
    bus.ef_valid_in = 1'b0;
    frame_done = 1'b1;
    arb_step(0);
    @(negedge clk);
    frame_done = 1'b0;
    chk("start_hi", bus.ef_start_out, 1);
    arb_step(1);
    @(negedge clk);
    chk("x_center", bus.ef_x_center_out, xc);
    chk("y_center", bus.ef_y_center_out, yc);
    k = 0;
    while (busy && k < T + 4) begin
      chk("start_lo", bus.ef_start_out, 0);
      if (k == rst_at) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_start", bus.ef_start_out, 0);
        chk("rst_bvld", bvld, 0);
        chk_state("rst");
        arb_step(0);
        return;
      end
      frame_done      = (k == 2);
      bus.ef_valid_in = give && (k == dly);
      bus.ef_right_in = bus.ef_valid_in ? EDGE_X_W'(r) : EDGE_X_W'($urandom);
      bus.ef_left_in  = bus.ef_valid_in ? EDGE_X_W'(l) : EDGE_X_W'($urandom);
      bus.ef_top_in   = bus.ef_valid_in ? EDGE_Y_W'(t) : EDGE_Y_W'($urandom);
      bus.ef_bot_in   = bus.ef_valid_in ? EDGE_Y_W'(b) : EDGE_Y_W'($urandom);
      arb_step(1);
      @(negedge clk);
      k++;
    end
    frame_done = 1'b0;
    bus.ef_valid_in = 1'b0;
    if (give) begin
      chk("scan_len", k, dly + 1);
      chk("bvld_check", bvld, 0);
      arb_step(0);
      acc = ref_accept(l, r, t, b);
      if (acc) begin
`ifdef EDGE_BOX_SMOOTH_EN
        if (m_locked()) begin
          l = (m_l + l + 1) / 2; r = (m_r + r + 1) / 2;
          t = (m_t + t + 1) / 2; b = (m_b + b + 1) / 2;
        end
`endif
        m_l = l; m_r = r; m_t = t; m_b = b;
        m_have = 1; m_fails = 0;
      end else begin
        m_fails++;
      end
      @(negedge clk);
      chk("bvld_pulse", bvld, acc);
    end else begin
      chk("scan_len", k, T);
      m_fails++;
      m_err = 1;
    end
    chk_state("post");
    // Stray frame_done/valid outside their windows must not start or publish anything.
    repeat (3) begin
      bus.ef_valid_in = 1'($urandom_range(0, 1));
      bus.ef_right_in = 11'd200; bus.ef_left_in = 11'd40;
      bus.ef_top_in   = 10'd50;  bus.ef_bot_in  = 10'd270;
      arb_step(0);
      @(negedge clk);
      chk("bvld_idle", bvld, 0);
    end
    bus.ef_valid_in = 1'b0;
    chk_state("idle");
  endtask

  initial begin
    int l, r, t, b, dly;
    bus.ef_addr_in = '0; bus.ef_valid_in = 1'b0; bus.disp_req_in = 1'b0; bus.disp_addr_in = '0;
    bus.ef_right_in = '0; bus.ef_left_in = '0; bus.ef_top_in = '0; bus.ef_bot_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_bvld", bvld, 0);
    chk("reset_start", bus.ef_start_out, 0);
    chk_state("reset");
    arb_step(0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Disabled: frame_done is ignored.
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    repeat (2) begin @(negedge clk); chk("idle_fd", busy, 0); end

    set_enable(1);
    do_scan(50, 40, 200, 50, 270, -1);
    repeat (3) do_scan(5, 100, 90, 50, 270, -1);
    do_scan(T - 1, 40, 200, 50, 270, -1);
    do_scan(20, 30, 210, 40, 280, -1);
    do_scan(3, 224, 239, 0, 15, -1);
    do_scan(3, 225, 239, 0, 15, -1);
    do_scan(3, 0, 240, 0, 100, -1);
    do_scan(3, 0, 100, 10, 320, -1);
    do_scan(-1, 0, 0, 0, 0, -1);
    set_enable(0);
    set_enable(1);
    chk("err_cleared", err, m_err);

    for (int i = 0; i < 30; i++) begin
      l = $urandom_range(0, 250); r = $urandom_range(0, 260);
      t = $urandom_range(0, 330); b = $urandom_range(0, 340);
      if ($urandom_range(0, 7) == 0) r = $urandom_range(0, 2047);
      dly = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, T - 1);
      do_scan(dly, l, r, t, b, -1);
      if ($urandom_range(0, 5) == 0) begin set_enable(0); set_enable(1); end
    end

    // Reset in the middle of a scan, with a frame_done seen earlier in that scan.
    do_scan(-1, 0, 0, 0, 0, 5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_state("after_rst");
    chk("after_rst_bvld", bvld, 0);
    repeat (4) begin arb_step(0); @(negedge clk); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_scan_ctrl.md
# edge_scan_ctrl

Sequencer and framebuffer read-port arbiter for the edge-finder datapath. On each completed camera frame it launches one edge scan and owns the shared single-port framebuffer read address while the scan runs; the display pipeline owns the port otherwise. It waits for the finder's result or a timeout, sanity-checks the bounding box, and publishes a latched, validated box plus lock/error status to downstream homography logic.

## Interface
- WIDTH, 240: frame width in pixels.
- HEIGHT, 320: frame height in pixels.
- TIMEOUT_CYCLES, 4096: maximum SCAN duration before the scan is declared failed.
- MIN_BOX, 16: minimum accepted box width and height, in pixels.
- MAX_RETRY, 3: consecutive failures tolerated before lock is dropped.
- ADDR_W = $clog2(WIDTH*HEIGHT), derived.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- enable_in  in  1  run the scan loop.
- frame_done_in  in  1  one-cycle pulse when a camera frame is fully written.
- x_center_in / y_center_in  in  11 / 10  scan centre, forwarded to the finder.
- ef_start_out  in→out  1  drives the finder's find_corners_flag.
- ef_x_center_out / ef_y_center_out  out  11 / 10  registered copy of the centre, captured in START.
- ef_addr_in  in  ADDR_W  finder read address.
- ef_valid_in  in  1  finder result pulse.
- ef_right_in / ef_left_in / ef_top_in / ef_bot_in  in  11/11/10/10  finder edges.
- disp_req_in  in  1  display read request.
- disp_addr_in  in  ADDR_W  display read address.
- disp_gnt_out  out  1  display owns the port this cycle.
- mem_addr_out  out  ADDR_W  framebuffer read address.
- box_right_out / box_left_out / box_top_out / box_bot_out  out  11/11/10/10  last accepted box.
- box_valid_out  out  1  one-cycle pulse when the box registers update.
- locked_out  out  1  a box is valid and fewer than MAX_RETRY failures have occurred since.
- err_timeout_out  out  1  sticky; set on any timeout; cleared by reset or by a rising edge of enable_in.
- busy_out  out  1  high in START and SCAN.

## Operation
- States: IDLE, ARM, START, SCAN, CHECK.
- IDLE → ARM when enable_in = 1.
- ARM → START on frame_done_in. In IDLE and ARM, enable_in = 0 returns the FSM to IDLE.
- START: lasts one cycle. ef_start_out = 1, centre captured, timeout counter cleared. Next state is SCAN.
- SCAN: ef_start_out = 0.
  - ef_valid_in = 1 → capture the four edges, go to CHECK.
  - Counter reaches TIMEOUT_CYCLES - 1 with no valid → failure; set err_timeout_out; go to ARM, or to IDLE if enable_in = 0.
  - enable_in changes during SCAN are deferred to the end of the scan.
- CHECK: lasts one cycle. Accept iff all of:
  - left < right, top < bot;
  - right < WIDTH, bot < HEIGHT;
  - right - left + 1 ≥ MIN_BOX and bot - top + 1 ≥ MIN_BOX.
  - Compare in 12-bit unsigned arithmetic with no wrap.
- On accept: update the box registers, pulse box_valid_out, set locked_out, clear the fail counter.
- On reject: increment the 2-bit-saturating fail counter; no box update.
- Any failure (reject or timeout) with fail counter reaching MAX_RETRY clears locked_out. The box registers keep their last value.
- frame_done_in outside ARM is ignored; there is no pending flag.
- ef_valid_in outside SCAN is ignored.
- Arbitration is combinational:
  - In START or SCAN: mem_addr_out = ef_addr_in, disp_gnt_out = 0.
  - Otherwise: mem_addr_out = disp_addr_in, disp_gnt_out = disp_req_in.

## Timing
- Reset (async assert, sync deassert internally): state IDLE; all registered outputs 0; mem_addr_out = disp_addr_in.
- ef_start_out is high for exactly one cycle and low for at least one cycle before the next rise, so the finder sees a clean rising edge.
- The finder's read port is handed over in the START cycle, i.e. before its first address is issued.
- Latency from ef_valid_in to box_valid_out is 2 cycles: capture, then CHECK, then the registered pulse.
- A timeout ends SCAN exactly TIMEOUT_CYCLES cycles after START.
- If reset is asserted mid-SCAN, the port returns to display immediately and ef_start_out drops to 0.

## Configuration
- EDGE_BOX_SMOOTH_EN defined: while locked_out = 1, an accepted box is blended per edge as out = (old + new + 1) >> 1. The first box after lock loss is loaded raw.
- EDGE_BOX_SMOOTH_EN undefined: an accepted box is loaded raw every time.

## Structure
- Package edge_pkg holds:
  - the state enum;
  - box_t struct {right, left, top, bot};
  - the EDGE_X_W = 11 and EDGE_Y_W = 10 constants.
- Sub-module edge_box_check: purely combinational; inputs box_t, WIDTH, HEIGHT and MIN_BOX; output accept.

## Test plan
- Enable, frame_done pulse, finder returns L=40 R=200 T=50 B=270 after 900 cycles → ef_start_out high for 1 cycle, box_valid_out 2 cycles after ef_valid_in, box = 40/200/50/270, locked_out = 1.
- Finder never asserts valid, TIMEOUT_CYCLES = 64 → SCAN exits 64 cycles after START, err_timeout_out = 1, returns to ARM.
- Three consecutive rejects (L=100 R=90), starting from locked → locked_out drops after the third, box holds the previous value.
- disp_req_in held high through a scan → disp_gnt_out = 0 exactly during START and SCAN, mem_addr_out tracks ef_addr_in, then reverts to display.
- frame_done_in during SCAN, plus rst_in low mid-SCAN → no second scan is started; after reset all outputs are 0 and the state is IDLE.
- With EDGE_BOX_SMOOTH_EN defined, locked with R=200, next accept R=210 → box_right_out = 205.
